cnt_share_arbiter: RTL and testbench
====================================

Name: cnt_share_arbiter

Overview:
- Round-robin arbiter/sequencer that time-shares one flex_counter instance among NUM_REQ requesters, each asking for a timed interval of N counts.
- Latches the winner's rollover value and drives the counter's clear/count_enable/rollover_val.
- Watches rollover_flag and returns a one-cycle done pulse to the winner.
- Sits between protocol FSMs (AHB-lite slave timers, wait-state generators) and a single shared counter.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CNT_WIDTH, 4, counter width; must match the flex_counter NUM_CNT_BITS

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req  input  NUM_REQ  per-requester request level
req_val  input  NUM_REQ*CNT_WIDTH  packed interval lengths; slice i = bits [i*CNT_WIDTH +: CNT_WIDTH]
grant  output  NUM_REQ  one-hot; owner of the counter
done  output  NUM_REQ  one-cycle pulse to owner when its interval expires
busy  output  1  high whenever state != IDLE
cnt_clear  output  1  to flex_counter clear
cnt_enable  output  1  to flex_counter count_enable
cnt_rollover_val  output  CNT_WIDTH  to flex_counter rollover_val (latched value)
cnt_count_out  input  CNT_WIDTH  from flex_counter count_out
cnt_rollover_flag  input  1  from flex_counter rollover_flag

Behaviour:
- Reset (async, immediate): state IDLE, rr pointer 0, latched index 0, latched value 0. All outputs 0 (grant, done, busy, cnt_clear, cnt_enable, cnt_rollover_val).
- FSM states: IDLE, CLEAR, COUNT, DONE.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from the rr pointer, with wrap.
  - Latch its index and req_val slice; a slice of 0 is latched as 1.
  - Go to CLEAR. No req -> stay.
- CLEAR: cnt_clear=1, cnt_enable=0 for exactly one cycle, then COUNT.
- COUNT:
  - cnt_enable = ~cnt_rollover_flag (combinational), so the counter freezes at the rollover value and never wraps.
  - When cnt_rollover_flag=1 -> DONE.
- DONE:
  - done[idx]=1 for one cycle.
  - rr pointer <= idx+1, wrapping modulo NUM_REQ.
  - Go to IDLE.
- grant[idx] is registered; high throughout CLEAR, COUNT and DONE; 0 in IDLE.
- cnt_rollover_val holds the latched value from CLEAR through DONE; in IDLE it keeps the last latched value.
- Latency: grant rises at edge E0 (entry to CLEAR); done rises at edge E0+N+2, where N is the latched value. Minimum one IDLE cycle between consecutive grants.
- req_val and req changes after latch are ignored until DONE. Dropping req mid-interval does not abort (see optional feature).
- A requester holding req after its done is re-served only after all other pending requesters (fairness).
- Simultaneous requests: lowest index at or above the pointer wins.
- cnt_count_out is unused for control; it is only compared under the optional feature.
- Arithmetic: the pointer increment wraps modulo NUM_REQ; no other arithmetic.

Optional Feature:
- Macro: CNT_SHARE_ARBITER_ABORT_EN.
- Defined:
  - In COUNT, if req[idx] falls, go to IDLE next cycle with no done pulse.
  - cnt_clear pulses for 1 cycle in that transition cycle; rr pointer still advances to idx+1.
  - In DONE, assert done only if cnt_count_out equals the latched value; otherwise suppress it.
- Undefined: req deassertion is ignored mid-interval; done always pulses in DONE.

Test Plan:
- Reset: rst=1 mid-stream -> grant=0, done=0, busy=0, cnt_clear=0, cnt_enable=0 within the same cycle; after release, state IDLE, pointer 0.
- Single request with a real flex_counter attached, req[0]=1, val=3:
  - grant=0001 at E0, cnt_clear high only in cycle E0..E0+1;
  - count goes 1,2,3 and then holds 3 (no wrap to 1);
  - done[0] pulses at E0+5, busy falls at E0+6.
- All four requests at once, vals 1,2,3,4, all held until their done: grants in order 0001, 0010, 0100, 1000; done spacing 3,4,5,6 cycles plus 1 IDLE cycle each.
- Fairness: req[0] and req[2] held permanently, val=2 -> grant sequence 0001, 0100, 0001, 0100…; never two consecutive grants to the same index.
- Zero value: req[1]=1, val=0 -> cnt_rollover_val=1, done[1] at E0+3.
- Abort (macro defined): req[3], val=15, req[3] dropped after 4 counts -> no done[3], one cnt_clear pulse, return to IDLE. Without the macro: done[3] still at E0+17.

Source files
------------

// File: rtl/cnt_share_arbiter_if.sv
// Requester and counter-side signals of the shared-counter arbiter.
// slave = arbiter view, master = requesters plus flex_counter view.
interface cnt_share_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int CNT_WIDTH = 4
);
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*CNT_WIDTH-1:0] req_val;
    logic [NUM_REQ-1:0]           grant;
    logic [NUM_REQ-1:0]           done;
    logic                         busy;
    logic                         cnt_clear;
    logic                         cnt_enable;
    logic [CNT_WIDTH-1:0]         cnt_rollover_val;
    logic [CNT_WIDTH-1:0]         cnt_count_out;
    logic                         cnt_rollover_flag;

    modport slave (
        input  req, req_val, cnt_count_out, cnt_rollover_flag,
        output grant, done, busy, cnt_clear, cnt_enable, cnt_rollover_val
    );

    modport master (
        output req, req_val, cnt_count_out, cnt_rollover_flag,
        input  grant, done, busy, cnt_clear, cnt_enable, cnt_rollover_val
    );
endinterface

// File: rtl/cnt_share_arbiter.sv
// Round-robin sequencer time-sharing one flex_counter among NUM_REQ requesters.
// Optional CNT_SHARE_ARBITER_ABORT_EN: abort on req drop, gate done on count match.
module cnt_share_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int CNT_WIDTH = 4
) (
    input logic                 clk,
    input logic                 rst,
    cnt_share_arbiter_if.slave  bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, CLEAR, COUNT, DONE} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d, idx_q, idx_d;
    logic [CNT_WIDTH-1:0] val_q, val_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;

    logic                 found;
    logic [IDX_W-1:0]     pick, cand, ptr_nxt;
    logic [CNT_WIDTH-1:0] pick_val;
    logic                 clr, en;
    logic [NUM_REQ-1:0]   done_v;

    // First requester at or above the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (int'(ptr_q) + k >= NUM_REQ)
                cand = IDX_W'(int'(ptr_q) + k - NUM_REQ);
            else
                cand = IDX_W'(int'(ptr_q) + k);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign pick_val = bus.req_val[int'(pick)*CNT_WIDTH +: CNT_WIDTH];
    assign ptr_nxt  = (idx_q == IDX_W'(NUM_REQ-1)) ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        val_d   = val_q;
        grant_d = grant_q;
        clr     = 1'b0;
        en      = 1'b0;
        done_v  = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    idx_d   = pick;
                    val_d   = (pick_val == '0) ? CNT_WIDTH'(1) : pick_val;
                    grant_d = NUM_REQ'(1) << pick;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                clr     = 1'b1;
                state_d = COUNT;
            end
            COUNT: begin
                // Freeze at the rollover value instead of letting the counter wrap.
                en = ~bus.cnt_rollover_flag;
`ifdef CNT_SHARE_ARBITER_ABORT_EN
                if (!bus.req[idx_q]) begin
                    en      = 1'b0;
                    clr     = 1'b1;
                    grant_d = '0;
                    ptr_d   = ptr_nxt;
                    state_d = IDLE;
                end else if (bus.cnt_rollover_flag) begin
                    state_d = DONE;
                end
`else
                if (bus.cnt_rollover_flag)
                    state_d = DONE;
`endif
            end
            DONE: begin
`ifdef CNT_SHARE_ARBITER_ABORT_EN
                if (bus.cnt_count_out == val_q)
                    done_v = grant_q;
`else
                done_v = grant_q;
`endif
                ptr_d   = ptr_nxt;
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            val_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
            grant_q <= grant_d;
        end
    end

`ifndef CNT_SHARE_ARBITER_ABORT_EN
    logic unused_cnt;
    assign unused_cnt = ^bus.cnt_count_out;
`endif

    assign bus.grant            = grant_q;
    assign bus.done             = done_v;
    assign bus.busy             = (state_q != IDLE);
    assign bus.cnt_clear        = clr;
    assign bus.cnt_enable       = en;
    assign bus.cnt_rollover_val = val_q;
endmodule

// File: tb/tb_cnt_share_arbiter.sv
// Directed bench for cnt_share_arbiter with a behavioural flex_counter attached.
// Expectations track CNT_SHARE_ARBITER_ABORT_EN when it is defined.
module tb_cnt_share_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   nchk = 0;
    int   nfail = 0;

    cnt_share_arbiter_if #(.NUM_REQ(4), .CNT_WIDTH(4)) bus ();

    cnt_share_arbiter #(.NUM_REQ(4), .CNT_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference flex_counter: sync clear, wraps to 1, registered rollover flag.
    logic [3:0] cnt_q, cnt_d;
    logic       flag_q;
    always_comb begin
        cnt_d = cnt_q;
        if (bus.cnt_clear)       cnt_d = '0;
        else if (bus.cnt_enable) cnt_d = (cnt_q == bus.cnt_rollover_val) ? 4'd1 : cnt_q + 4'd1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= (cnt_d == bus.cnt_rollover_val);
        end
    end
    assign bus.cnt_count_out     = cnt_q;
    assign bus.cnt_rollover_flag = flag_q;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_grant(output logic [3:0] g, output int gap, output int e0);
        g = '0; gap = 0; e0 = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); @(negedge clk);
            gap++;
            if (bus.grant != '0) begin
                g = bus.grant; e0 = cyc;
                return;
            end
        end
        chk("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int e0, output logic [3:0] d, output int lat);
        d = '0; lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); @(negedge clk);
            if (bus.done != '0) begin
                d = bus.done; lat = cyc - e0;
                return;
            end
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    logic [3:0] g, d, acc;
    int gap, e0, lat;
    logic [3:0] exp_cnt [4] = '{4'd1, 4'd2, 4'd3, 4'd3};

    initial begin
        bus.req = '0;
        bus.req_val = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_clear", 32'(bus.cnt_clear), 0);
        chk("rst_enable", 32'(bus.cnt_enable), 0);
        chk("rst_rov", 32'(bus.cnt_rollover_val), 0);

        // Single request, value 3
        bus.req = 4'b0001;
        bus.req_val = {4'd0, 4'd0, 4'd0, 4'd3};
        wait_grant(g, gap, e0);
        chk("s_grant", 32'(g), 32'b0001);
        chk("s_clear_e0", 32'(bus.cnt_clear), 1);
        chk("s_en_e0", 32'(bus.cnt_enable), 0);
        chk("s_busy_e0", 32'(bus.busy), 1);
        chk("s_rov_e0", 32'(bus.cnt_rollover_val), 3);
        bus.req_val = {4'd0, 4'd0, 4'd0, 4'd7};
        @(negedge clk);
        chk("s_clear_e1", 32'(bus.cnt_clear), 0);
        chk("s_en_e1", 32'(bus.cnt_enable), 1);
        chk("s_rov_e1", 32'(bus.cnt_rollover_val), 3);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("s_count", 32'(cnt_q), 32'(exp_cnt[k]));
            chk("s_done_vec", 32'(bus.done), (k == 3) ? 32'b0001 : 32'b0);
        end
        chk("s_done_lat", 32'(cyc - e0), 5);
        bus.req = '0;
        @(negedge clk);
        chk("s_busy_e6", 32'(bus.busy), 0);
        chk("s_grant_e6", 32'(bus.grant), 0);
        chk("s_rov_hold", 32'(bus.cnt_rollover_val), 3);

        // Mid-stream asynchronous reset
        bus.req = 4'b0010;
        bus.req_val = {4'd0, 4'd0, 4'd5, 4'd0};
        wait_grant(g, gap, e0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ar_grant", 32'(bus.grant), 0);
        chk("ar_done", 32'(bus.done), 0);
        chk("ar_busy", 32'(bus.busy), 0);
        chk("ar_clear", 32'(bus.cnt_clear), 0);
        chk("ar_enable", 32'(bus.cnt_enable), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.req = '0;
        @(negedge clk);
        chk("ar_idle", 32'(bus.busy), 0);

        // Four simultaneous requests, values 1..4
        bus.req = 4'b1111;
        bus.req_val = {4'd4, 4'd3, 4'd2, 4'd1};
        for (int i = 0; i < 4; i++) begin
            wait_grant(g, gap, e0);
            chk("a4_grant", 32'(g), 32'(4'b0001 << i));
            chk("a4_gap", 32'(gap), (i == 0) ? 32'd1 : 32'd2);
            wait_done(e0, d, lat);
            chk("a4_done", 32'(d), 32'(4'b0001 << i));
            chk("a4_lat", 32'(lat), 32'(i + 3));
            bus.req = bus.req & ~(4'b0001 << i);
        end

        // Zero interval is served as 1
        bus.req = 4'b0010;
        bus.req_val = '0;
        wait_grant(g, gap, e0);
        chk("z_grant", 32'(g), 32'b0010);
        chk("z_rov", 32'(bus.cnt_rollover_val), 1);
        wait_done(e0, d, lat);
        chk("z_done", 32'(d), 32'b0010);
        chk("z_lat", 32'(lat), 3);
        bus.req = '0;

        // Fairness between two permanent requesters
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req = 4'b0101;
        bus.req_val = {4'd0, 4'd2, 4'd0, 4'd2};
        for (int i = 0; i < 4; i++) begin
            wait_grant(g, gap, e0);
            chk("f_grant", 32'(g), (i % 2 == 0) ? 32'b0001 : 32'b0100);
            wait_done(e0, d, lat);
            chk("f_lat", 32'(lat), 4);
        end

        // Requester 3 drops its request after 4 counts
        bus.req = 4'b1000;
        bus.req_val = {4'd15, 4'd0, 4'd0, 4'd2};
        wait_grant(g, gap, e0);
        chk("ab_grant", 32'(g), 32'b1000);
        repeat (5) @(negedge clk);
        chk("ab_count", 32'(cnt_q), 4);
        bus.req = '0;
        #1;
`ifdef CNT_SHARE_ARBITER_ABORT_EN
        chk("ab_clear", 32'(bus.cnt_clear), 1);
        @(negedge clk);
        chk("ab_busy", 32'(bus.busy), 0);
        chk("ab_grant_off", 32'(bus.grant), 0);
        acc = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            acc = acc | bus.done;
        end
        chk("ab_no_done", 32'(acc), 0);
`else
        chk("ab_clear", 32'(bus.cnt_clear), 0);
        wait_done(e0, d, lat);
        chk("ab_done", 32'(d), 32'b1000);
        chk("ab_lat", 32'(lat), 17);
`endif

        // Pointer wrapped past requester 3 to 0
        bus.req = 4'b1001;
        wait_grant(g, gap, e0);
        chk("w_grant", 32'(g), 32'b0001);
        wait_done(e0, d, lat);
        chk("w_lat", 32'(lat), 4);
        bus.req = '0;

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
